// File: rtl/ysyx_23060124_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: access sizes, master IDs,
// FSM states, and the alignment rule used by both the arbiter and the aligner.
package ysyx_23060124_mem_arbiter_pkg;

  localparam int ISA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // The reserved size encoding is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_align.sv
// Byte-lane steering for LSU accesses: store strobes and data shifted up into
// their lanes, load data shifted down to bit 0.
module ysyx_23060124_lsu_align
  import ysyx_23060124_mem_arbiter_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           addr_lo,
  input  logic [ISA_WIDTH-1:0] wdata,
  input  logic [ISA_WIDTH-1:0] rdata,
  output logic [3:0]           wstrb,
  output logic [ISA_WIDTH-1:0] wdata_sh,
  output logic [ISA_WIDTH-1:0] rdata_sh,
  output logic                 misaligned
);

  logic [4:0] shamt;

  always_comb begin
    shamt      = {addr_lo, 3'b000};
    wdata_sh   = wdata << shamt;
    rdata_sh   = rdata >> shamt;
    misaligned = is_misaligned(size, addr_lo);
    case (size)
      SIZE_B:  wstrb = 4'b0001 << addr_lo;
      SIZE_H:  wstrb = 4'b0011 << addr_lo;
      SIZE_W:  wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port with a single outstanding
// transaction; misaligned LSU accesses are answered locally with an error.
module ysyx_23060124_mem_arbiter
  import ysyx_23060124_mem_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  // IFU
  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [ISA_WIDTH-1:0] ifu_addr,
  output logic                 ifu_resp_valid,
  input  logic                 ifu_resp_ready,
  output logic [ISA_WIDTH-1:0] ifu_rdata,
  output logic                 ifu_resp_err,
  // LSU
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic [ISA_WIDTH-1:0] lsu_addr,
  input  logic                 lsu_wen,
  input  logic [1:0]           lsu_size,
  input  logic [ISA_WIDTH-1:0] lsu_wdata,
  output logic                 lsu_resp_valid,
  input  logic                 lsu_resp_ready,
  output logic [ISA_WIDTH-1:0] lsu_rdata,
  output logic                 lsu_resp_err,
  // Memory
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ISA_WIDTH-1:0] mem_addr,
  output logic                 mem_wen,
  output logic [ISA_WIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_resp_valid,
  output logic                 mem_resp_ready,
  input  logic [ISA_WIDTH-1:0] mem_rdata,
  input  logic                 mem_resp_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Requesters may drop valid before being granted; once granted, the request
  // is held in local registers and memory-side valid stays stable until ready.

  state_e               state_q, state_d;
  mst_e                 ptr_q, ptr_d;
  mst_e                 owner_q, owner_d;
  logic [ISA_WIDTH-1:0] addr_q, addr_d;
  logic                 wen_q, wen_d;
  logic [1:0]           size_q, size_d;
  logic [ISA_WIDTH-1:0] wdata_q, wdata_d;

  mst_e                 winner;
  logic                 grant;
  logic [3:0]           al_wstrb;
  logic [ISA_WIDTH-1:0] al_wdata;
  logic [ISA_WIDTH-1:0] al_rdata;
  logic                 al_mis;
  logic                 unused_al_mis;

  ysyx_23060124_lsu_align u_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_sh   (al_wdata),
    .rdata_sh   (al_rdata),
    .misaligned (al_mis)
  );

  // The misaligned decision is taken on the live request before latching,
  // so the aligner's copy of it is not needed here.
  assign unused_al_mis = al_mis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= MST_IFU;
      owner_q <= MST_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    mem_addr       = {addr_q[ISA_WIDTH-1:2], 2'b00};
    mem_wen        = wen_q;
    mem_wdata      = al_wdata;
    mem_wstrb      = wen_q ? al_wstrb : 4'b0000;

    if (ifu_req_valid && lsu_req_valid) winner = ptr_q;
    else if (lsu_req_valid)              winner = MST_LSU;
    else                                 winner = MST_IFU;
    // Reset gating keeps ready low while reset is held with a request pending.
    grant = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid) && !reset;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = winner;
          ptr_d   = (winner == MST_IFU) ? MST_LSU : MST_IFU;
          if (winner == MST_LSU) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            size_d        = lsu_size;
            wdata_d       = lsu_wdata;
            state_d       = is_misaligned(lsu_size, lsu_addr[1:0]) ? ST_ERR : ST_REQ;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            size_d        = SIZE_W;
            wdata_d       = '0;
            state_d       = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q == MST_LSU) begin
          mem_resp_ready = lsu_resp_ready;
          lsu_resp_valid = mem_resp_valid;
          lsu_resp_err   = mem_resp_err;
          lsu_rdata      = (wen_q || mem_resp_err) ? '0 : al_rdata;
        end else begin
          mem_resp_ready = ifu_resp_ready;
          ifu_resp_valid = mem_resp_valid;
          ifu_resp_err   = mem_resp_err;
          ifu_rdata      = mem_rdata;
        end
        if (mem_resp_valid && mem_resp_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        lsu_resp_valid = 1'b1;
        lsu_resp_err   = 1'b1;
        if (lsu_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: vector table plus hand-written
// sequences for arbitration fairness and reset during a transaction.
module tb_ysyx_23060124_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];
  logic exp_q[$];

  ysyx_23060124_mem_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_size       (lsu_size),
    .lsu_wdata      (lsu_wdata),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_rdata      (lsu_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0;
    ifu_addr       = 32'h0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = 32'h0;
    lsu_wen        = 1'b0;
    lsu_size       = 2'd0;
    lsu_wdata      = 32'h0;
    lsu_resp_ready = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    mem_resp_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Driver: one request from the vector's master, memory answers at the
  // earliest legal cycle so the latency is checked as well.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clock);
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = v.addr;
      lsu_wen       = v.wen;
      lsu_size      = v.size;
      lsu_wdata     = v.wdata;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = v.addr;
    end
    #1;
    chk1($sformatf("v%0d req_ready", i), v.is_lsu ? lsu_req_ready : ifu_req_ready, 1'b1);
    @(posedge clock); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (v.exp_mis) begin
      chk1($sformatf("v%0d mis mem_req_valid", i), mem_req_valid, 1'b0);
      chk1($sformatf("v%0d mis resp_valid", i), lsu_resp_valid, 1'b1);
      chk1($sformatf("v%0d mis resp_err", i), lsu_resp_err, 1'b1);
      chk32($sformatf("v%0d mis rdata", i), lsu_rdata, 32'h0);
      lsu_resp_ready = 1'b1;
      @(posedge clock); #1;
      lsu_resp_ready = 1'b0;
      chk1($sformatf("v%0d mis after resp_valid", i), lsu_resp_valid, 1'b0);
      chk1($sformatf("v%0d mis after mem_req_valid", i), mem_req_valid, 1'b0);
    end else begin
      chk1($sformatf("v%0d mem_req_valid", i), mem_req_valid, 1'b1);
      chk32($sformatf("v%0d mem_addr", i), mem_addr, v.exp_addr);
      chk32($sformatf("v%0d mem_wstrb", i), {28'h0, mem_wstrb}, {28'h0, v.exp_wstrb});
      chk32($sformatf("v%0d mem_wdata", i), mem_wdata, v.exp_wdata);
      chk1($sformatf("v%0d mem_wen", i), mem_wen, v.wen);
      mem_req_ready = 1'b1;
      @(posedge clock); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = v.m_rdata;
      mem_resp_err   = v.m_err;
      ifu_resp_ready = 1'b1;
      lsu_resp_ready = 1'b1;
      #1;
      chk1($sformatf("v%0d mem_resp_ready", i), mem_resp_ready, 1'b1);
      if (v.is_lsu) begin
        chk1($sformatf("v%0d lsu_resp_valid", i), lsu_resp_valid, 1'b1);
        chk32($sformatf("v%0d lsu_rdata", i), lsu_rdata, v.exp_rdata);
        chk1($sformatf("v%0d lsu_resp_err", i), lsu_resp_err, v.exp_err);
        chk1($sformatf("v%0d ifu_resp_valid", i), ifu_resp_valid, 1'b0);
      end else begin
        chk1($sformatf("v%0d ifu_resp_valid", i), ifu_resp_valid, 1'b1);
        chk32($sformatf("v%0d ifu_rdata", i), ifu_rdata, v.exp_rdata);
        chk1($sformatf("v%0d ifu_resp_err", i), ifu_resp_err, v.exp_err);
        chk1($sformatf("v%0d lsu_resp_valid", i), lsu_resp_valid, 1'b0);
      end
      @(posedge clock); #1;
      clear_inputs();
    end
  endtask

  initial begin
    int grants;
    int cyc;
    int ifu_cnt;
    int lsu_cnt;
    logic got;

    reset = 1'b1;
    clear_inputs();
    //        lsu   addr          wen   size  wdata         m_rdata       m_err mis   exp_addr      strb   exp_wdata     exp_rdata     err
    vecs[0]  = '{1'b0, 32'h8000_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0413, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0000_0000, 32'h0000_0413, 1'b0};
    vecs[1]  = '{1'b1, 32'h8000_1003, 1'b1, 2'd0, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_1000, 4'h8, 32'hAB00_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_1002, 1'b0, 2'd1, 32'h0000_0000, 32'hBEEF_1234, 1'b0, 1'b0, 32'h8000_1000, 4'h0, 32'h0000_0000, 32'h0000_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_1001, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'h8000_0006, 1'b1, 2'd1, 32'h0000_CAFE, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0004, 4'hC, 32'hCAFE_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0008, 1'b1, 2'd2, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0008, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0001, 1'b0, 2'd0, 32'h0000_0000, 32'h1122_3344, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0000_0000, 32'h0011_2233, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_000C, 1'b0, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h8000_000C, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h8000_0010, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0055, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0000_0000, 32'h0000_0055, 1'b1};
    vecs[9]  = '{1'b1, 32'h8000_0003, 1'b1, 2'd1, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h8000_0000, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h8000_0002, 1'b1, 2'd0, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0000, 4'h4, 32'hFF5A_0000, 32'h0000_0000, 1'b0};

    // Reset state, with a request already pending from the IFU
    ifu_req_valid = 1'b1;
    #2;
    chk1("rst ifu_req_ready", ifu_req_ready, 1'b0);
    chk1("rst lsu_req_ready", lsu_req_ready, 1'b0);
    chk1("rst mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst mem_resp_ready", mem_resp_ready, 1'b0);
    chk1("rst ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk1("rst lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk32("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    ifu_req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Both masters requesting every cycle: grants alternate from IFU
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(k[0]);
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0020;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_2000;
    lsu_wen        = 1'b0;
    lsu_size       = 2'd2;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0001;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    grants  = 0;
    cyc     = 0;
    ifu_cnt = 0;
    lsu_cnt = 0;
    while (grants < 6 && cyc < 60) begin
      #1;
      if (ifu_req_ready && lsu_req_ready) begin
        chk1("rr both ready", 1'b1, 1'b0);
      end else if (ifu_req_ready || lsu_req_ready) begin
        got = lsu_req_ready;
        chk1($sformatf("rr grant %0d", grants), got, exp_q.pop_front());
        if (got) lsu_cnt++;
        else     ifu_cnt++;
        grants++;
      end
      @(negedge clock);
      cyc++;
    end
    chk32("rr grant count", grants, 32'd6);
    chk32("rr ifu served", ifu_cnt, 32'd3);
    chk32("rr lsu served", lsu_cnt, 32'd3);
    clear_inputs();

    // Reset while parked in RESP with the response not yet accepted
    do_reset();
    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0030;
    @(posedge clock); #1;
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0077;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_0040;
    lsu_size       = 2'd2;
    #1;
    chk1("mid ifu_resp_valid", ifu_resp_valid, 1'b1);
    chk1("mid mem_resp_ready", mem_resp_ready, 1'b0);
    chk1("mid lsu_req_ready", lsu_req_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk1("rst2 ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk32("rst2 ifu_rdata", ifu_rdata, 32'h0);
    chk1("rst2 mem_resp_ready", mem_resp_ready, 1'b0);
    chk1("rst2 mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst2 lsu_req_ready", lsu_req_ready, 1'b0);
    chk32("rst2 mem_addr", mem_addr, 32'h0);
    @(negedge clock);
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk1("post rst mem_req_valid", mem_req_valid, 1'b0);
    chk1("post rst ifu_resp_valid", ifu_resp_valid, 1'b0);
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
